store_narrow_buffer: RTL and testbench
======================================

// Module: store_narrow_buffer
// PURPOSE
//  Store-side counterpart of the load extender: narrows 32-bit register data to
//  byte/halfword/word writes with byte enables, checks alignment, and queues
//  stores in a DEPTH-entry FIFO. Sits between the MEM stage and the bridge/DM
//  write port; the bus side drains entries with a valid/ready handshake.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2); CNT_W = $clog2(DEPTH)+1 (localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  req_valid  in   1      store request from MEM stage
//  req_ready  out  1      = !full (combinational)
//  req_type   in   2      00 sw, 01 sh, 10 sb, 11 illegal
//  req_addr   in   32     byte address
//  req_data   in   32     register rt value
//  exc_valid  out  1      1-cycle pulse: previous accepted request misaligned/illegal
//  exc_addr   out  32     offending req_addr (held until next exception)
//  bus_valid  out  1      = !empty
//  bus_ready  in   1      bus accepts head entry
//  bus_addr   out  32     {head_addr[31:2],2'b00}
//  bus_be     out  4      head byte enables
//  bus_wdata  out  32     head lane-replicated data
//  count      out  CNT_W  entries held, 0..DEPTH
// BEHAVIOUR
//  Reset values: count=0, bus_valid=0, bus_addr/bus_be/bus_wdata=0,
//   exc_valid=0, exc_addr=0, req_ready=1; rd/wr pointers=0.
//  Accept = req_valid & req_ready. On accept, narrowing rules:
//   sw: addr[1:0]==0 required; be=4'b1111; wdata=data
//   sh: addr[0]==0 required; be=addr[1]?4'b1100:4'b0011; wdata={2{data[15:0]}}
//   sb: be=4'b0001<<addr[1:0]; wdata={4{data[7:0]}}
//   illegal type or misaligned: NOT enqueued; exc_valid=1 next cycle,
//   exc_addr<=req_addr. Handshake still completes.
//  Latency: valid enqueue at edge N -> on bus from cycle N+1. No bypass when
//   empty; no push when full, even if a pop happens in the same cycle.
//  Pop = bus_valid & bus_ready; rd pointer advances, head outputs show next
//   entry from the following cycle.
//  bus_addr/be/wdata stay stable while bus_valid & !bus_ready. When empty they
//   show the last slot read; the bus must ignore them.
//  Push+pop in the same cycle (not full): count unchanged; both pointers advance.
//  Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
//  Misaligned request + pop in the same cycle: pop proceeds; count -1.
//  Reset mid-operation: all queued stores are dropped; outputs return to reset
//   values asynchronously.
//  No internal FSM beyond the FIFO pointers/count; the exception flag is a 1-cycle
//   registered pulse.
// TESTING
//  1 sb addr=0x1003 data=0x123456AB, bus_ready=1 -> next cycle bus_addr=0x1000,
//    bus_be=1000, bus_wdata=0xABABABAB; count 1 then 0.
//  2 sh addr=0x2002 data=0xDEADBEEF -> be=1100, wdata=0xBEEFBEEF;
//    sh addr=0x2001 -> not queued; exc_valid pulse; exc_addr=0x2001.
//  3 bus_ready=0, push 4 sw (0x0,0x4,0x8,0xC) -> count=4, req_ready=0; a 5th
//    request is stalled. Raise bus_ready -> drained in order 0x0..0xC.
//  4 count=2, push+pop in the same cycle for 6 cycles -> count stays 2; FIFO order
//    kept across pointer wrap.
//  5 count=3, assert reset mid-cycle -> bus_valid=0 and count=0 immediately;
//    the queued stores never appear on the bus.
//  6 req_type=11 addr=0x0 -> exc_valid pulse; count unchanged.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer
//   Narrows 32-bit store data from the MEM stage to byte/halfword/word writes with
//   byte enables. Checks alignment and queues legal stores in a DEPTH-entry FIFO that
//   the bus side drains with a valid/ready handshake.
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready    store request handshake (req_ready = !full)
//   req_type               00 sw, 01 sh, 10 sb, 11 illegal
//   req_addr, req_data     byte address and register rt value
//   exc_valid, exc_addr    1-cycle pulse for a misaligned/illegal request, offending address
//   bus_valid/bus_ready    head-entry handshake (bus_valid = !empty)
//   bus_addr/be/wdata      head entry: word address, byte enables, lane-replicated data
//   count                  entries held, 0..DEPTH
module store_narrow_buffer #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             exc_valid,
    output logic [31:0]      exc_addr,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_be,
    output logic [31:0]      bus_wdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             exc_valid_q;
    logic [31:0]      exc_addr_q;

    // Only the word address is stored; the byte offset is folded into the enables.
    logic [29:0] mem_addr  [DEPTH];
    logic [3:0]  mem_be    [DEPTH];
    logic [31:0] mem_wdata [DEPTH];

    logic        full, empty, accept, legal, push, pop;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign accept = req_valid & ~full;
    assign push   = accept & legal;
    assign pop    = ~empty & bus_ready;

    always_comb begin
        legal   = 1'b0;
        be_n    = 4'b0000;
        wdata_n = req_data;
        unique case (req_type)
            2'b00: begin
                legal   = (req_addr[1:0] == 2'b00);
                be_n    = 4'b1111;
                wdata_n = req_data;
            end
            2'b01: begin
                legal   = ~req_addr[0];
                be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{req_data[15:0]}};
            end
            2'b10: begin
                legal   = 1'b1;
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_data[7:0]}};
            end
            2'b11: begin
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
            // Storage is cleared so the head outputs read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i]  <= '0;
                mem_be[i]    <= '0;
                mem_wdata[i] <= '0;
            end
        end else begin
            // Rejected requests still complete the handshake; they only raise the pulse.
            exc_valid_q <= accept & ~legal;
            if (accept & ~legal) begin
                exc_addr_q <= req_addr;
            end
            if (push) begin
                mem_addr[wr_ptr_q]  <= req_addr[31:2];
                mem_be[wr_ptr_q]    <= be_n;
                mem_wdata[wr_ptr_q] <= wdata_n;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign req_ready = ~full;
    assign bus_valid = ~empty;
    assign bus_addr  = {mem_addr[rd_ptr_q], 2'b00};
    assign bus_be    = mem_be[rd_ptr_q];
    assign bus_wdata = mem_wdata[rd_ptr_q];
    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
module tb_store_narrow_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_type = 2'b00;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_data = '0;
    logic             exc_valid;
    logic [31:0]      exc_addr;
    logic             bus_valid;
    logic             bus_ready = 1'b0;
    logic [31:0]      bus_addr;
    logic [3:0]       bus_be;
    logic [31:0]      bus_wdata;
    logic [CNT_W-1:0] count;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;

    store_narrow_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .exc_valid (exc_valid),
        .exc_addr  (exc_addr),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic bit legal_of(input logic [1:0] t, input logic [31:0] a);
        case (t)
            2'b00:   return a[1:0] == 2'b00;
            2'b01:   return a[0] == 1'b0;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic entry_t model(input logic [1:0] t, input logic [31:0] a,
                                     input logic [31:0] d);
        entry_t e;
        e.addr = {a[31:2], 2'b00};
        case (t)
            2'b00: begin
                e.be    = 4'b1111;
                e.wdata = d;
            end
            2'b01: begin
                e.be    = a[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{d[15:0]}};
            end
            default: begin
                e.be    = 4'b0001 << a[1:0];
                e.wdata = {4{d[7:0]}};
            end
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid = v;
        req_type  = t;
        req_addr  = a;
        req_data  = d;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin errors++; $display("FAIL reset_head: got %h/%b/%h expected zeros", bus_addr, bus_be, bus_wdata); end
        checks++; if (exc_valid !== 1'b0 || exc_addr !== 32'h0) begin errors++; $display("FAIL reset_exc: got %b/%h expected 0/0", exc_valid, exc_addr); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scenario 1: byte store at offset 3.
    task automatic test_sb();
        entry_t e;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, 2'b10, 32'h0000_1003, 32'h1234_56AB);
            else        drive(1'b0, 2'b00, 32'h0, 32'h0);
            @(negedge clk);
            if (i == 0) begin
                checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL sb_no_bypass: got bus_valid=%b expected 0", bus_valid); end
            end
            if (i == 1) begin
                checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL sb_count1: got %0d expected 1", count); end
                checks++; if (bus_addr !== 32'h1000 || bus_be !== 4'b1000 || bus_wdata !== 32'hABAB_ABAB) begin
                    errors++; $display("FAIL sb_lanes: got %h/%b/%h expected 00001000/1000/abababab", bus_addr, bus_be, bus_wdata); end
            end
            if (i == 2) begin
                checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL sb_count0: got %0d expected 0", count); end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL sb_extra: got %h with nothing expected", bus_addr); end
                else begin
                    e = sb.pop_front();
                    if ({bus_addr, bus_be, bus_wdata} !== e) begin errors++; $display("FAIL sb_entry: got %h/%b/%h expected %h/%b/%h", bus_addr, bus_be, bus_wdata, e.addr, e.be, e.wdata); end
                end
            end
            if (req_valid && req_ready && legal_of(req_type, req_addr)) sb.push_back(model(req_type, req_addr, req_data));
            @(posedge clk); #1;
        end
    endtask

    // Scenario 2: aligned halfword, then a misaligned one.
    task automatic test_sh();
        entry_t e;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      drive(1'b1, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF);
            else if (i == 1) drive(1'b1, 2'b01, 32'h0000_2001, 32'h1111_2222);
            else             drive(1'b0, 2'b00, 32'h0, 32'h0);
            @(negedge clk);
            if (i == 1) begin
                checks++; if (bus_be !== 4'b1100 || bus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_lanes: got %b/%h expected 1100/beefbeef", bus_be, bus_wdata); end
                checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL sh_no_exc: got %b expected 0", exc_valid); end
            end
            if (i == 2) begin
                checks++; if (exc_valid !== 1'b1 || exc_addr !== 32'h2001) begin errors++; $display("FAIL sh_exc: got %b/%h expected 1/00002001", exc_valid, exc_addr); end
                checks++; if (count !== CNT_W'(0) || bus_valid !== 1'b0) begin errors++; $display("FAIL sh_not_queued: got count=%0d valid=%b expected 0/0", count, bus_valid); end
            end
            if (i == 3) begin
                checks++; if (exc_valid !== 1'b0 || exc_addr !== 32'h2001) begin errors++; $display("FAIL sh_exc_pulse: got %b/%h expected 0/00002001", exc_valid, exc_addr); end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL sh_extra: got %h with nothing expected", bus_addr); end
                else begin
                    e = sb.pop_front();
                    if ({bus_addr, bus_be, bus_wdata} !== e) begin errors++; $display("FAIL sh_entry: got %h/%b/%h expected %h/%b/%h", bus_addr, bus_be, bus_wdata, e.addr, e.be, e.wdata); end
                end
            end
            if (req_valid && req_ready && legal_of(req_type, req_addr)) sb.push_back(model(req_type, req_addr, req_data));
            @(posedge clk); #1;
        end
    endtask

    // Scenario 3: fill to full, stall a 5th request, then drain in order.
    task automatic test_fill();
        entry_t e;
        for (int i = 0; i < 12; i++) begin
            bus_ready = (i >= 6);
            if (i < 4)      drive(1'b1, 2'b00, 32'(i * 4), 32'hA000_0000 + 32'(i));
            else if (i < 8) drive(1'b1, 2'b00, 32'h10, 32'h0000_00FF);
            else            drive(1'b0, 2'b00, 32'h0, 32'h0);
            @(negedge clk);
            if (i == 4 || i == 5 || i == 6) begin
                checks++; if (count !== CNT_W'(4) || req_ready !== 1'b0) begin errors++; $display("FAIL fill_full_c%0d: got count=%0d ready=%b expected 4/0", i, count, req_ready); end
            end
            if (i == 7) begin
                checks++; if (count !== CNT_W'(3) || req_ready !== 1'b1) begin errors++; $display("FAIL fill_no_push_when_full: got count=%0d ready=%b expected 3/1", count, req_ready); end
            end
            if (i == 11) begin
                checks++; if (count !== CNT_W'(0) || sb.size() != 0) begin errors++; $display("FAIL fill_drained: got count=%0d pending=%0d expected 0/0", count, sb.size()); end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL fill_extra: got %h with nothing expected", bus_addr); end
                else begin
                    e = sb.pop_front();
                    if ({bus_addr, bus_be, bus_wdata} !== e) begin errors++; $display("FAIL fill_entry: got %h/%b/%h expected %h/%b/%h", bus_addr, bus_be, bus_wdata, e.addr, e.be, e.wdata); end
                end
            end
            if (req_valid && req_ready && legal_of(req_type, req_addr)) sb.push_back(model(req_type, req_addr, req_data));
            @(posedge clk); #1;
        end
    endtask

    // Scenario 4: steady push+pop at count 2 across pointer wrap.
    task automatic test_back_to_back();
        entry_t e;
        for (int i = 0; i < 11; i++) begin
            bus_ready = (i >= 2);
            if (i < 2)      drive(1'b1, 2'b00, 32'h100 + 32'(i * 4), $urandom);
            else if (i < 8) drive(1'b1, 2'b10, 32'h200 + 32'(i), $urandom);
            else            drive(1'b0, 2'b00, 32'h0, 32'h0);
            @(negedge clk);
            if (i >= 2 && i <= 8) begin
                checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL b2b_count_c%0d: got %0d expected 2", i, count); end
            end
            if (i == 10) begin
                checks++; if (count !== CNT_W'(0) || sb.size() != 0) begin errors++; $display("FAIL b2b_drained: got count=%0d pending=%0d expected 0/0", count, sb.size()); end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h with nothing expected", bus_addr); end
                else begin
                    e = sb.pop_front();
                    if ({bus_addr, bus_be, bus_wdata} !== e) begin errors++; $display("FAIL b2b_entry: got %h/%b/%h expected %h/%b/%h", bus_addr, bus_be, bus_wdata, e.addr, e.be, e.wdata); end
                end
            end
            if (req_valid && req_ready && legal_of(req_type, req_addr)) sb.push_back(model(req_type, req_addr, req_data));
            @(posedge clk); #1;
        end
    endtask

    // Scenario 6: illegal type with no pop, then misaligned word alongside a pop.
    task automatic test_exception();
        entry_t e;
        for (int i = 0; i < 5; i++) begin
            bus_ready = (i >= 3);
            if (i == 0)      drive(1'b1, 2'b00, 32'h300, 32'h5555_AAAA);
            else if (i == 1) drive(1'b1, 2'b11, 32'h0, 32'hFFFF_FFFF);
            else if (i == 3) drive(1'b1, 2'b00, 32'h306, 32'h1234_5678);
            else             drive(1'b0, 2'b00, 32'h0, 32'h0);
            @(negedge clk);
            if (i == 2) begin
                checks++; if (exc_valid !== 1'b1 || exc_addr !== 32'h0) begin errors++; $display("FAIL exc_illegal: got %b/%h expected 1/00000000", exc_valid, exc_addr); end
                checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL exc_count_kept: got %0d expected 1", count); end
            end
            if (i == 4) begin
                checks++; if (exc_valid !== 1'b1 || exc_addr !== 32'h306) begin errors++; $display("FAIL exc_misaligned: got %b/%h expected 1/00000306", exc_valid, exc_addr); end
                checks++; if (count !== CNT_W'(0) || bus_valid !== 1'b0) begin errors++; $display("FAIL exc_pop_proceeds: got count=%0d valid=%b expected 0/0", count, bus_valid); end
            end
            if (bus_valid && bus_ready) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL exc_extra: got %h with nothing expected", bus_addr); end
                else begin
                    e = sb.pop_front();
                    if ({bus_addr, bus_be, bus_wdata} !== e) begin errors++; $display("FAIL exc_entry: got %h/%b/%h expected %h/%b/%h", bus_addr, bus_be, bus_wdata, e.addr, e.be, e.wdata); end
                end
            end
            if (req_valid && req_ready && legal_of(req_type, req_addr)) sb.push_back(model(req_type, req_addr, req_data));
            @(posedge clk); #1;
        end
    endtask

    // Scenario 5: asynchronous reset with three stores queued.
    task automatic test_reset_mid();
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'h400 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            @(posedge clk); #1;
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL rst_mid_pre: got count=%0d expected 3", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== CNT_W'(0) || bus_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_async: got count=%0d valid=%b ready=%b expected 0/0/1", count, bus_valid, req_ready); end
        checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0 || exc_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h/%b/%h exc=%h expected zeros", bus_addr, bus_be, bus_wdata, exc_addr); end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_dropped_c%0d: got bus_valid=%b addr=%h expected 0", i, bus_valid, bus_addr); end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_fill();
        test_back_to_back();
        test_exception();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
